ddc_amp_avg: RTL and testbench
==============================

DDC_AMP_AVG -- requirements
Module: ddc_amp_avg

Interface
REQ-001 SHALL have parameter DATAIN_WIDTH, default 25, amplitude sample width (unsigned).
REQ-002 SHALL have parameter AVG_LOG2_MAX, default 10, largest supported log2 of window length.
REQ-003 SHALL have port clk_i  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port en_i  in  1  block enable.
REQ-006 SHALL have port clear_i  in  1  synchronous clear of partial window, overrun and peak.
REQ-007 SHALL have port data_i  in  DATAIN_WIDTH  amplitude sample from upstream DDC.
REQ-008 SHALL have port val_i  in  1  data_i qualifier (upstream val_o).
REQ-009 SHALL have port log2n_i  in  4  window length = 2^log2n_i samples.
REQ-010 SHALL have port avg_o  out  DATAIN_WIDTH  window mean.
REQ-011 SHALL have port val_o  out  1  avg_o holds an unconsumed result.
REQ-012 SHALL have port rdy_i  in  1  downstream accepts avg_o when val_o and rdy_i are both high.
REQ-013 SHALL have port overrun_o  out  1  sticky flag: a completed window was dropped.
REQ-014 SHALL have port peak_o  out  DATAIN_WIDTH  maximum sample of the last delivered window (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE and ACC; IDLE->ACC when en_i=1; ACC->IDLE when en_i=0, discarding the partial window.
REQ-016 SHALL latch log2n_i on the first accepted sample of each window; later changes take effect only at the next window.
REQ-017 SHALL clamp latched log2n to AVG_LOG2_MAX when log2n_i exceeds it; log2n=0 gives a 1-sample window.
REQ-018 SHALL accumulate into an accumulator of DATAIN_WIDTH+AVG_LOG2_MAX bits, so it never overflows.
REQ-019 SHALL count accepted samples (val_i=1 in ACC) and complete the window on sample 2^log2n, restarting the next window on the following sample with no gap.
REQ-020 SHALL produce the mean as accumulator right-shifted by log2n, truncated (no rounding).
REQ-021 SHALL register the mean into avg_o and assert val_o the cycle after the last sample (latency 1).
REQ-022 SHALL hold avg_o and val_o stable until the handshake; val_o deasserts the cycle after val_o&rdy_i unless a new result loads the same cycle.
REQ-023 SHALL load a completing window when val_o=0 or rdy_i=1 in that cycle; otherwise it SHALL drop the result, keep the old avg_o and set overrun_o.
REQ-024 SHALL give clear_i priority over val_i: the same-cycle sample is discarded, counter and accumulator zeroed, overrun_o and peak cleared; avg_o/val_o are unaffected.
REQ-025 SHALL ignore val_i while in IDLE; en_i=0 does not clear avg_o, val_o or overrun_o.

Reset
REQ-026 SHALL, while rst_n_i=0, force FSM to IDLE and avg_o, val_o, overrun_o, peak_o, counter, accumulator to zero.
REQ-027 SHALL, on reset mid-window, discard the partial window; first window after release starts with the first accepted sample.

Configuration
REQ-028 SHALL compile peak tracking only when macro DDC_AMP_AVG_PEAK_EN is defined: running max per window, copied to peak_o when avg_o loads.
REQ-029 SHALL, without DDC_AMP_AVG_PEAK_EN, tie peak_o to zero and omit the max register.

Structure
REQ-030 SHALL place the FSM state type, the 4-bit log2n width constant and the clamp function in shared package ddc_pkg.
REQ-031 SHALL be a single module with no sub-modules; the accumulator/counter datapath is inline.

Verification
REQ-032 log2n_i=2, en_i=1, samples 10,20,30,41 with val_i=1, rdy_i=1 -> avg_o=25, val_o pulses 1 cycle after sample 4, peak_o=41 (macro on) or 0 (off).
REQ-033 log2n_i=0, continuous val_i with samples 7,9 -> avg_o=7 then 9 on consecutive cycles, no overrun.
REQ-034 log2n_i=1, rdy_i=0, samples 4,6,8,10 -> avg_o stays 5, second window dropped, overrun_o=1; clear_i -> overrun_o=0, avg_o still 5.
REQ-035 log2n_i=15 with AVG_LOG2_MAX=10, 1024 samples of 2^25-1 -> avg_o=2^25-1, window completes on sample 1024.
REQ-036 log2n_i=2, two samples, then rst_n_i low 1 cycle, then 4 samples of 8 -> avg_o=8; same with en_i toggled low instead of reset -> avg_o=8.

Source files
------------

// File: rtl/ddc_pkg.sv
// Shared types and helpers for the DDC amplitude averager.
package ddc_pkg;

    localparam int unsigned LOG2N_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Limit a requested window exponent to the largest supported one.
    function automatic logic [LOG2N_W-1:0] clamp_log2n(
        input logic [LOG2N_W-1:0] log2n,
        input int unsigned        max_log2
    );
        if (32'(log2n) > max_log2) begin
            return LOG2N_W'(max_log2);
        end
        return log2n;
    endfunction

endpackage

// File: rtl/ddc_amp_avg.sv
// Power-of-two window mean of DDC amplitude samples with a valid/ready output.
// Optional per-window peak tracking is built when DDC_AMP_AVG_PEAK_EN is defined.
module ddc_amp_avg
    import ddc_pkg::*;
#(
    parameter int unsigned DATAIN_WIDTH = 25,
    parameter int unsigned AVG_LOG2_MAX = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic                    clear_i,
    input  logic [DATAIN_WIDTH-1:0] data_i,
    input  logic                    val_i,
    input  logic [LOG2N_W-1:0]      log2n_i,
    output logic [DATAIN_WIDTH-1:0] avg_o,
    output logic                    val_o,
    input  logic                    rdy_i,
    output logic                    overrun_o,
    output logic [DATAIN_WIDTH-1:0] peak_o
);

    localparam int unsigned ACC_W = DATAIN_WIDTH + AVG_LOG2_MAX;
    localparam int unsigned CNT_W = AVG_LOG2_MAX + 1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [ACC_W-1:0]        r_acc;
    logic [LOG2N_W-1:0]      r_log2n;

    logic                    w_in_acc;
    logic                    w_accept;
    logic                    w_first;
    logic [LOG2N_W-1:0]      w_len;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [CNT_W-1:0]        w_win_len;
    logic                    w_last;
    logic [ACC_W-1:0]        w_acc_sum;
    logic [DATAIN_WIDTH-1:0] w_mean;
    logic                    w_load;
    logic                    w_drop;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (en_i)  w_state_next = ACC;
            ACC:     if (!en_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // The window exponent is taken live on the first sample and held afterwards.
    assign w_in_acc  = (r_state == ACC) && en_i;
    assign w_accept  = w_in_acc && val_i && !clear_i;
    assign w_first   = (r_cnt == '0);
    assign w_len     = w_first ? clamp_log2n(log2n_i, AVG_LOG2_MAX) : r_log2n;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_win_len = CNT_W'(1) << w_len;
    assign w_last    = w_accept && (w_cnt_inc == w_win_len);
    assign w_acc_sum = r_acc + ACC_W'(data_i);
    assign w_mean    = DATAIN_WIDTH'(w_acc_sum >> w_len);
    assign w_load    = w_last && (!val_o || rdy_i);
    assign w_drop    = w_last && val_o && !rdy_i;

    // Window accumulator and sample counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_log2n <= '0;
        end else if (!w_in_acc || clear_i) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
                r_acc <= w_acc_sum;
            end
            if (w_first) begin
                r_log2n <= w_len;
            end
        end
    end

    // Result register with valid/ready hold and overrun flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            avg_o     <= '0;
            val_o     <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (w_load) begin
                avg_o <= w_mean;
                val_o <= 1'b1;
            end else if (val_o && rdy_i) begin
                val_o <= 1'b0;
            end
            if (clear_i) begin
                overrun_o <= 1'b0;
            end else if (w_drop) begin
                overrun_o <= 1'b1;
            end
        end
    end

`ifdef DDC_AMP_AVG_PEAK_EN
    logic [DATAIN_WIDTH-1:0] r_max;
    logic [DATAIN_WIDTH-1:0] w_max_next;

    assign w_max_next = (w_first || (data_i > r_max)) ? data_i : r_max;

    // Running maximum of the open window, published alongside the mean
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_max  <= '0;
            peak_o <= '0;
        end else begin
            if (!w_in_acc || clear_i) begin
                r_max <= '0;
            end else if (w_accept) begin
                r_max <= w_max_next;
            end
            if (clear_i) begin
                peak_o <= '0;
            end else if (w_load) begin
                peak_o <= w_max_next;
            end
        end
    end
`else
    assign peak_o = '0;
`endif

endmodule

// File: tb/tb_ddc_amp_avg.sv
// Self-checking bench for ddc_amp_avg: directed scenarios plus randomized traffic
// against a window-list reference model.
module tb_ddc_amp_avg;

    localparam int unsigned DW   = 25;
    localparam int unsigned LMAX = 10;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic          clr   = 1'b0;
    logic          val   = 1'b0;
    logic          rdy   = 1'b0;
    logic [DW-1:0] data  = '0;
    logic [3:0]    l2n   = '0;
    logic [DW-1:0] avg;
    logic [DW-1:0] peak;
    logic          vo;
    logic          ovr;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the open window as a list of samples
    int unsigned   q[$];
    int            m_len;
    bit            m_acc;
    logic [DW-1:0] m_avg;
    logic [DW-1:0] m_peak;
    bit            m_val;
    bit            m_ovr;

    always #5 clk = ~clk;

    ddc_amp_avg #(
        .DATAIN_WIDTH(DW),
        .AVG_LOG2_MAX(LMAX)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .en_i     (en),
        .clear_i  (clr),
        .data_i   (data),
        .val_i    (val),
        .log2n_i  (l2n),
        .avg_o    (avg),
        .val_o    (vo),
        .rdy_i    (rdy),
        .overrun_o(ovr),
        .peak_o   (peak)
    );

    task automatic model_reset();
        q.delete();
        m_acc  = 1'b0;
        m_avg  = '0;
        m_peak = '0;
        m_val  = 1'b0;
        m_ovr  = 1'b0;
        m_len  = 0;
    endtask

    task automatic model_cycle();
        bit          loaded;
        bit          hs;
        longint      sum;
        int unsigned mx;
        loaded = 1'b0;
        hs     = m_val && rdy;
        if (m_acc && en && val && !clr) begin
            if (q.size() == 0) m_len = (l2n > LMAX) ? int'(LMAX) : int'(l2n);
            q.push_back(int'(data));
            if (q.size() == (1 << m_len)) begin
                sum = 0;
                mx  = 0;
                foreach (q[i]) begin
                    sum += longint'(q[i]);
                    if (q[i] > mx) mx = q[i];
                end
                if (!m_val || rdy) begin
                    m_avg  = DW'(sum / (longint'(1) << m_len));
                    m_val  = 1'b1;
                    loaded = 1'b1;
`ifdef DDC_AMP_AVG_PEAK_EN
                    m_peak = DW'(mx);
`endif
                end else begin
                    m_ovr = 1'b1;
                end
                q.delete();
            end
        end
        if (clr) begin
            q.delete();
            m_ovr  = 1'b0;
            m_peak = '0;
        end
        if (!(m_acc && en)) q.delete();
        if (hs && !loaded) m_val = 1'b0;
        m_acc = en;
    endtask

    task automatic tick();
        @(posedge clk);
        model_cycle();
        #1;
    endtask

    task automatic set_in(input bit e, input bit c, input bit v, input logic [DW-1:0] d,
                          input logic [3:0] l, input bit r);
        en = e; clr = c; val = v; data = d; l2n = l; rdy = r;
    endtask

    task automatic apply_reset();
        set_in(0, 0, 0, '0, 4'd0, 0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_in(1, 0, 1, DW'(123), 4'd0, 1);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (avg !== '0) begin n_err++; $display("FAIL reset_avg: got %0d want 0", avg); end
        n_vec++;
        if (vo !== 1'b0) begin n_err++; $display("FAIL reset_val: got %0b want 0", vo); end
        n_vec++;
        if (ovr !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %0b want 0", ovr); end
        n_vec++;
        if (peak !== '0) begin n_err++; $display("FAIL reset_peak: got %0d want 0", peak); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int unsigned smp[4] = '{10, 20, 30, 41};
        logic [DW-1:0] exp_peak;
`ifdef DDC_AMP_AVG_PEAK_EN
        exp_peak = DW'(41);
`else
        exp_peak = '0;
`endif
        apply_reset();
        set_in(1, 0, 0, '0, 4'd2, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 1, DW'(smp[i]), 4'd2, 1);
            tick();
            n_vec++;
            if ({avg, vo, ovr, peak} !== {m_avg, m_val, m_ovr, m_peak}) begin
                n_err++;
                $display("FAIL basic[%0d]: got avg=%0d val=%0b ovr=%0b peak=%0d want avg=%0d val=%0b ovr=%0b peak=%0d",
                         i, avg, vo, ovr, peak, m_avg, m_val, m_ovr, m_peak);
            end
        end
        n_vec++;
        if (avg !== DW'(25) || vo !== 1'b1) begin
            n_err++; $display("FAIL basic_mean: got avg=%0d val=%0b want avg=25 val=1", avg, vo);
        end
        n_vec++;
        if (peak !== exp_peak) begin n_err++; $display("FAIL basic_peak: got %0d want %0d", peak, exp_peak); end
        set_in(1, 0, 0, '0, 4'd2, 1);
        tick();
        n_vec++;
        if (vo !== 1'b0) begin n_err++; $display("FAIL basic_pulse: got val=%0b want 0", vo); end
    endtask

    task automatic test_single();
        apply_reset();
        set_in(1, 0, 0, '0, 4'd0, 1);
        tick();
        set_in(1, 0, 1, DW'(7), 4'd0, 1);
        tick();
        n_vec++;
        if (avg !== DW'(7) || vo !== 1'b1) begin
            n_err++; $display("FAIL single_first: got avg=%0d val=%0b want avg=7 val=1", avg, vo);
        end
        set_in(1, 0, 1, DW'(9), 4'd0, 1);
        tick();
        n_vec++;
        if (avg !== DW'(9) || vo !== 1'b1 || ovr !== 1'b0) begin
            n_err++; $display("FAIL single_second: got avg=%0d val=%0b ovr=%0b want avg=9 val=1 ovr=0", avg, vo, ovr);
        end
    endtask

    task automatic test_overrun();
        int unsigned smp[4] = '{4, 6, 8, 10};
        apply_reset();
        set_in(1, 0, 0, '0, 4'd1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 1, DW'(smp[i]), 4'd1, 0);
            tick();
            n_vec++;
            if ({avg, vo, ovr, peak} !== {m_avg, m_val, m_ovr, m_peak}) begin
                n_err++;
                $display("FAIL overrun[%0d]: got avg=%0d val=%0b ovr=%0b peak=%0d want avg=%0d val=%0b ovr=%0b peak=%0d",
                         i, avg, vo, ovr, peak, m_avg, m_val, m_ovr, m_peak);
            end
        end
        n_vec++;
        if (avg !== DW'(5) || vo !== 1'b1 || ovr !== 1'b1) begin
            n_err++; $display("FAIL overrun_set: got avg=%0d val=%0b ovr=%0b want avg=5 val=1 ovr=1", avg, vo, ovr);
        end
        set_in(1, 1, 0, '0, 4'd1, 0);
        tick();
        n_vec++;
        if (avg !== DW'(5) || vo !== 1'b1 || ovr !== 1'b0) begin
            n_err++; $display("FAIL overrun_clear: got avg=%0d val=%0b ovr=%0b want avg=5 val=1 ovr=0", avg, vo, ovr);
        end
    endtask

    task automatic test_clamp();
        logic [DW-1:0] ones;
        ones = '1;
        apply_reset();
        set_in(1, 0, 0, '0, 4'd15, 1);
        tick();
        for (int i = 0; i < 1024; i++) begin
            set_in(1, 0, 1, ones, 4'd15, 1);
            tick();
            n_vec++;
            if ({avg, vo, ovr, peak} !== {m_avg, m_val, m_ovr, m_peak}) begin
                n_err++;
                $display("FAIL clamp[%0d]: got avg=%0d val=%0b ovr=%0b peak=%0d want avg=%0d val=%0b ovr=%0b peak=%0d",
                         i, avg, vo, ovr, peak, m_avg, m_val, m_ovr, m_peak);
            end
            if (i == 1022) begin
                n_vec++;
                if (vo !== 1'b0) begin n_err++; $display("FAIL clamp_early: got val=%0b want 0", vo); end
            end
        end
        n_vec++;
        if (avg !== ones || vo !== 1'b1) begin
            n_err++; $display("FAIL clamp_mean: got avg=%0d val=%0b want avg=%0d val=1", avg, vo, ones);
        end
    endtask

    task automatic test_restart();
        for (int mode = 0; mode < 2; mode++) begin
            apply_reset();
            set_in(1, 0, 0, '0, 4'd2, 1);
            tick();
            for (int i = 0; i < 2; i++) begin
                set_in(1, 0, 1, DW'(100 + i), 4'd2, 1);
                tick();
            end
            if (mode == 0) begin
                rst_n = 1'b0;
                model_reset();
                set_in(1, 0, 0, '0, 4'd2, 1);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                tick();
            end else begin
                set_in(0, 0, 0, '0, 4'd2, 1);
                tick();
                set_in(1, 0, 0, '0, 4'd2, 1);
                tick();
            end
            for (int i = 0; i < 4; i++) begin
                set_in(1, 0, 1, DW'(8), 4'd2, 1);
                tick();
                n_vec++;
                if ({avg, vo, ovr, peak} !== {m_avg, m_val, m_ovr, m_peak}) begin
                    n_err++;
                    $display("FAIL restart%0d[%0d]: got avg=%0d val=%0b ovr=%0b peak=%0d want avg=%0d val=%0b ovr=%0b peak=%0d",
                             mode, i, avg, vo, ovr, peak, m_avg, m_val, m_ovr, m_peak);
                end
            end
            n_vec++;
            if (avg !== DW'(8) || vo !== 1'b1) begin
                n_err++; $display("FAIL restart%0d_mean: got avg=%0d val=%0b want avg=8 val=1", mode, avg, vo);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            d = ($urandom_range(0, 9) == 0) ? '1 : DW'($urandom);
            set_in(($urandom_range(0, 59) != 0), ($urandom_range(0, 49) == 0),
                   ($urandom_range(0, 9) < 7), d, 4'($urandom_range(0, 4)),
                   ($urandom_range(0, 9) < 6));
            tick();
            n_vec++;
            if ({avg, vo, ovr, peak} !== {m_avg, m_val, m_ovr, m_peak}) begin
                n_err++;
                $display("FAIL random[%0d]: got avg=%0d val=%0b ovr=%0b peak=%0d want avg=%0d val=%0b ovr=%0b peak=%0d",
                         i, avg, vo, ovr, peak, m_avg, m_val, m_ovr, m_peak);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_overrun();
        test_clamp();
        test_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
